// File: rtl/rv32_seq_pkg.sv
// Shared types and defaults for the RV32 multi-cycle sequencer.
// The performance counters are enabled by the RV32_SEQ_PERF_CNT_EN macro.
package rv32_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } seq_state_t;

  localparam int SEQ_TIMEOUT_DEF = 255;

endpackage

// File: rtl/rv32_seq_watchdog.sv
// Memory-handshake watchdog: counts consecutive wait cycles and pulses
// o_expire when the count has reached the limit and the wait persists.
module rv32_seq_watchdog
  import rv32_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEF,
  parameter int CW             = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_wait,
  input  logic [CW-1:0] i_limit,
  output logic          o_expire
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit    = WD_EN && i_wait && (r_cnt == i_limit);
  assign o_expire = w_hit;

  // Consecutive-wait counter; holds at the limit so it can never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_wait && !w_hit) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/rv32_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Optional cycle/instret counters are built when RV32_SEQ_PERF_CNT_EN is defined.
module rv32_multicycle_sequencer
  import rv32_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEF,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_halt,
  output logic             o_imem_req,
  input  logic             i_imem_ready,
  output logic             o_ir_we,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_regwen,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ready,
  output logic             o_pc_we,
  output logic             o_rf_we,
  output logic [2:0]       o_state,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  seq_state_t r_state;
  logic       r_imem_req;
  logic       r_dmem_req;
  logic       r_dmem_we;
  logic       r_pc_we;
  logic       r_rf_we;
  logic       r_err;
  logic       w_wait;
  logic       w_expire;

  assign w_wait = ((r_state == S_FETCH) && !i_imem_ready) ||
                  ((r_state == S_MEM)   && !i_dmem_ready);

  rv32_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_wait),
    .i_wait   (w_wait),
    .i_limit  (WD_W'(TIMEOUT_CYCLES)),
    .o_expire (w_expire)
  );

  // State register plus outputs registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_pc_we    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_pc_we    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_err      <= r_err;
      case (r_state)
        S_IDLE, S_WB, S_HALT: begin
          if (i_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_imem_ready) begin
            r_state <= S_DECODE;
          end else if (w_expire) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (i_is_load || i_is_store) begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= i_is_store;
          end else begin
            r_state <= S_WB;
            r_pc_we <= 1'b1;
            r_rf_we <= i_regwen & ~i_is_store;
          end
        end
        S_MEM: begin
          if (i_dmem_ready) begin
            r_state <= S_WB;
            r_pc_we <= 1'b1;
            r_rf_we <= i_regwen & ~i_is_store;
          end else if (w_expire) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= i_is_store;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_ERR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign o_imem_req = r_imem_req;
  assign o_dmem_req = r_dmem_req;
  assign o_dmem_we  = r_dmem_we;
  assign o_pc_we    = r_pc_we;
  assign o_rf_we    = r_rf_we;
  assign o_err      = r_err;
  assign o_state    = r_state;
  assign o_ir_we    = (r_state == S_FETCH) && i_imem_ready;

`ifdef RV32_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // Free-running cycle and retired-instruction counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_ERR) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end else begin
        r_cycle_cnt <= r_cycle_cnt;
      end
      if (r_state == S_WB) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end else begin
        r_instret_cnt <= r_instret_cnt;
      end
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  assign o_cycle_cnt   = '0;
  assign o_instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32_multicycle_sequencer.sv
// Scoreboard bench for rv32_multicycle_sequencer: per-instruction expectations
// are queued at issue and checked when the DUT reaches WB.
module tb_rv32_multicycle_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_HALT  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  logic        clk;
  logic        rst;
  logic        i_halt;
  logic        o_imem_req;
  logic        i_imem_ready;
  logic        o_ir_we;
  logic        i_is_load;
  logic        i_is_store;
  logic        i_regwen;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        i_dmem_ready;
  logic        o_pc_we;
  logic        o_rf_we;
  logic [2:0]  o_state;
  logic        o_err;
  logic [31:0] o_cycle_cnt;
  logic [31:0] o_instret_cnt;

  rv32_multicycle_sequencer #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_halt        (i_halt),
    .o_imem_req    (o_imem_req),
    .i_imem_ready  (i_imem_ready),
    .o_ir_we       (o_ir_we),
    .i_is_load     (i_is_load),
    .i_is_store    (i_is_store),
    .i_regwen      (i_regwen),
    .o_dmem_req    (o_dmem_req),
    .o_dmem_we     (o_dmem_we),
    .i_dmem_ready  (i_dmem_ready),
    .o_pc_we       (o_pc_we),
    .o_rf_we       (o_rf_we),
    .o_state       (o_state),
    .o_err         (o_err),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instret_cnt (o_instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   lat;
    logic rf;
    logic we;
    int   memc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fc = 0, dc = 0, iw = 0, dw = 0;
  bit   istall = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: ready after iw (fetch) / dw (data) wait cycles
  task automatic update_ready();
    if (o_state == ST_FETCH) begin
      i_imem_ready = !istall && (fc == iw);
      fc++;
    end else begin
      i_imem_ready = 1'b0;
      fc = 0;
    end
    if (o_state == ST_MEM) begin
      i_dmem_ready = (dc == dw);
      dc++;
    end else begin
      i_dmem_ready = 1'b0;
      dc = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    update_ready();
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store
  task automatic push_exp(input int kind, input bit regwen, input int iwait, input int dwait);
    exp_t e;
    i_is_load  = (kind == 1);
    i_is_store = (kind == 2);
    i_regwen   = regwen;
    iw = iwait;
    dw = dwait;
    e.lat  = 4 + iwait + ((kind != 0) ? (1 + dwait) : 0);
    e.rf   = regwen && (kind != 2);
    e.we   = (kind == 2);
    e.memc = (kind != 0) ? (dwait + 1) : 0;
    sb.push_back(e);
  endtask

  task automatic run_instr(input int kind, input bit regwen, input int iwait, input int dwait,
                           output logic [31:0] trace);
    int n;
    push_exp(kind, regwen, iwait, dwait);
    trace = 32'h0;
    n = 0;
    do begin
      step();
      trace = {trace[27:0], 1'b0, o_state};
      n++;
    end while (o_state != ST_WB && n < 60);
    check_eq("wb_reached", {29'h0, o_state}, {29'h0, ST_WB});
  endtask

  // Monitor: tracks latency and MEM occupancy, pops the scoreboard at WB
  initial begin : monitor
    int       lat_c;
    int       mem_c;
    logic [2:0] prev_st;
    exp_t     e;
    lat_c = 0;
    mem_c = 0;
    prev_st = ST_IDLE;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_state == ST_FETCH && prev_st != ST_FETCH) begin
          lat_c = 1;
          mem_c = 0;
        end else begin
          lat_c++;
        end
        check_eq("dmem_req", {31'h0, o_dmem_req}, {31'h0, (o_state == ST_MEM)});
        check_eq("pc_we_pulse", {31'h0, o_pc_we}, {31'h0, (o_state == ST_WB)});
        if (o_state == ST_MEM) begin
          mem_c++;
          if (sb.size() > 0) check_eq("dmem_we", {31'h0, o_dmem_we}, {31'h0, sb[0].we});
        end
        if (o_state == ST_WB) begin
          if (sb.size() == 0) begin
            check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check_eq("rf_we", {31'h0, o_rf_we}, {31'h0, e.rf});
            check_eq("latency", 32'(lat_c), 32'(e.lat));
            check_eq("mem_cycles", 32'(mem_c), 32'(e.memc));
          end
        end else begin
          check_eq("rf_we_idle", {31'h0, o_rf_we}, 32'h0);
        end
      end
      prev_st = o_state;
    end
  end

  initial begin : stim
    logic [31:0] tr;
    int          n;
    rst = 1'b1;
    i_halt = 1'b0;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    i_is_load = 1'b0;
    i_is_store = 1'b0;
    i_regwen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {29'h0, o_state}, 32'h0);
    check_eq("rst_outs", {25'h0, o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we, o_rf_we, o_err}, 32'h0);
    check_eq("rst_cycle_cnt", o_cycle_cnt, 32'h0);
    check_eq("rst_instret_cnt", o_instret_cnt, 32'h0);
    rst = 1'b0;

    run_instr(0, 1'b1, 0, 0, tr);
    check_eq("alu_trace", tr, 32'h0000_1235);
    run_instr(1, 1'b1, 0, 3, tr);
    check_eq("load_trace", tr, 32'h1234_4445);
    run_instr(2, 1'b1, 0, 1, tr);
    run_instr(0, 1'b0, 2, 0, tr);
    run_instr(1, 1'b1, 1, 0, tr);

    // Halt requested in EXEC: WB completes, then HALT until release
    push_exp(0, 1'b1, 0, 0);
    n = 0;
    do begin step(); n++; end while (o_state != ST_EXEC && n < 20);
    i_halt = 1'b1;
    step();
    check_eq("halt_wb", {29'h0, o_state}, {29'h0, ST_WB});
    step();
    check_eq("halt_enter", {29'h0, o_state}, {29'h0, ST_HALT});
    step();
    check_eq("halt_hold", {29'h0, o_state}, {29'h0, ST_HALT});
    i_halt = 1'b0;
    iw = 0;
    step();
    check_eq("halt_release", {29'h0, o_state}, {29'h0, ST_FETCH});
    check_eq("halt_imem_req", {31'h0, o_imem_req}, 32'h1);
    run_instr(0, 1'b1, 0, 0, tr);

    for (int i = 0; i < 6; i++) begin
      run_instr($urandom_range(2, 0), 1'($urandom_range(1, 0)),
                $urandom_range(3, 0), $urandom_range(3, 0), tr);
    end

    // Reset while a load waits in MEM
    i_is_load = 1'b1; i_is_store = 1'b0; i_regwen = 1'b1; iw = 0; dw = 3;
    n = 0;
    do begin step(); n++; end while (o_state != ST_MEM && n < 20);
    check_eq("mem_reached", {29'h0, o_state}, {29'h0, ST_MEM});
    rst = 1'b1;
    step();
    check_eq("mrst_state", {29'h0, o_state}, {29'h0, ST_IDLE});
    check_eq("mrst_dmem_req", {31'h0, o_dmem_req}, 32'h0);
    check_eq("mrst_cycle_cnt", o_cycle_cnt, 32'h0);
    check_eq("mrst_instret_cnt", o_instret_cnt, 32'h0);
    rst = 1'b0;

    // Watchdog: instruction memory never answers
    istall = 1'b1;
    i_is_load = 1'b0;
    step();
    n = 0;
    while (o_state == ST_FETCH && n < 20) begin
      n++;
      step();
    end
    check_eq("wd_fetch_cycles", 32'(n), 32'd5);
    check_eq("wd_state", {29'h0, o_state}, {29'h0, ST_ERR});
    check_eq("wd_err", {31'h0, o_err}, 32'h1);
    check_eq("wd_imem_req", {31'h0, o_imem_req}, 32'h0);
    istall = 1'b0;
    repeat (3) step();
    check_eq("err_sticky_state", {29'h0, o_state}, {29'h0, ST_ERR});
    check_eq("err_sticky", {31'h0, o_err}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("err_rst_state", {29'h0, o_state}, {29'h0, ST_IDLE});
    check_eq("err_rst_err", {31'h0, o_err}, 32'h0);

    check_eq("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_sequencer.md
# rv32_multicycle_sequencer

Multi-cycle control sequencer for the RV32I core: steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and owns the memory handshakes. It sits between the combinational RV32 decode/controller and the PC, IR, register file and memory ports. It gates the controller's per-instruction signals into single-cycle enables so one shared ALU/datapath serves every stage. A watchdog forces an error state on memory that never responds.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles for a memory handshake; 0 disables the watchdog.
- `CNT_W`, default 32: performance counter width (used only under the macro).

- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `i_halt` in 1: halt request, sampled only at instruction boundaries.
- `o_imem_req` out 1: instruction fetch request.
- `i_imem_ready` in 1: fetch data valid this cycle.
- `o_ir_we` out 1: load the instruction register.
- `i_is_load` in 1: decoded load, valid from DECODE onward.
- `i_is_store` in 1: decoded store, valid from DECODE onward.
- `i_regwen` in 1: RegWEn from the controller.
- `o_dmem_req` out 1: data memory request.
- `o_dmem_we` out 1: data write (store).
- `i_dmem_ready` in 1: data access complete this cycle.
- `o_pc_we` out 1: commit the next PC.
- `o_rf_we` out 1: register file write strobe.
- `o_state` out 3: current state encoding.
- `o_err` out 1: sticky memory-timeout error.
- `o_cycle_cnt` out CNT_W: cycle counter (macro only).
- `o_instret_cnt` out CNT_W: retired-instruction counter (macro only).

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: goes to HALT if `i_halt`, else to FETCH.
- FETCH:
  - `o_imem_req`=1 for as long as the state lasts.
  - When `i_imem_ready`=1: `o_ir_we`=1 in the same cycle, then go to DECODE.
- DECODE: goes to EXEC unconditionally after one cycle.
- EXEC: goes to MEM if `i_is_load|i_is_store`, else to WB.
- MEM:
  - `o_dmem_req`=1 and `o_dmem_we`=`i_is_store`.
  - When `i_dmem_ready`=1, go to WB.
- WB:
  - `o_pc_we`=1 and `o_rf_we`=`i_regwen & ~i_is_store`, both for exactly one cycle.
  - Then go to HALT if `i_halt`, else to FETCH.
- HALT: stays while `i_halt`=1; goes to FETCH on the first cycle `i_halt`=0.
- ERR: `o_err`=1, all requests low. Only `rst` leaves this state.
- Watchdog:
  - Counts consecutive FETCH/MEM cycles with the ready input low.
  - Cleared on every state change.
  - When the count equals `TIMEOUT_CYCLES` and ready is still low, go to ERR.
  - If ready and timeout occur in the same cycle, ready wins.
- Outputs are Moore (decoded from the state register), except `o_ir_we`, which is FETCH & `i_imem_ready`.
- `i_halt` during FETCH or MEM is ignored until WB, so no in-flight access is ever abandoned.

## Timing
- Reset values:
  - state=IDLE.
  - All outputs 0, including `o_err`; `o_state`=0.
  - Counters 0.
- `rst` mid-operation: state=IDLE at the next edge; requests and enables drop in that same cycle. The memory side must tolerate an aborted request.
- Latency with zero-wait memory, counted from FETCH entry to `o_pc_we`:
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds one.
- Back-to-back: WB is followed directly by FETCH; there is no bubble.
- Watchdog boundary: with `TIMEOUT_CYCLES`=N, ERR is entered after N+1 consecutive not-ready cycles in one state.

## Configuration
- Macro: `RV32_SEQ_PERF_CNT_EN`.
- Defined:
  - `o_cycle_cnt` increments every cycle outside ERR.
  - `o_instret_cnt` increments on every WB cycle.
  - Both wrap modulo 2^CNT_W and clear on `rst`.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `rv32_seq_pkg` holds:
  - `seq_state_t` enum with the fixed encodings above.
  - Default `TIMEOUT_CYCLES` constant.
- Sub-module `rv32_seq_watchdog`:
  - Inputs: clear, wait, limit.
  - Output: one-cycle expire pulse.
  - Counter width is clog2(TIMEOUT_CYCLES+1).

## Test plan
- ALU op, zero-wait memory, `i_regwen`=1 → states 1,2,3,5 in order; `o_pc_we`=`o_rf_we`=1 on cycle 4; `o_dmem_req` never asserted.
- Load, `i_dmem_ready` delayed 3 cycles → MEM lasts 4 cycles with `o_dmem_we`=0; `o_rf_we`=1 in WB; total 8 cycles.
- Store, `i_regwen`=1 → `o_dmem_we`=1 throughout MEM; `o_rf_we`=0 in WB.
- `i_halt`=1 asserted during EXEC → WB completes, state becomes HALT; release → FETCH on the next cycle.
- `TIMEOUT_CYCLES`=4, `i_imem_ready` held low → ERR after 5 FETCH cycles; `o_err`=1 stays set until `rst`, then state=IDLE.
- `rst` asserted during MEM → next cycle state=IDLE, `o_dmem_req`=0; with the macro defined, both counters read 0.
